// File: rtl/alu_opa_fwd_stage.sv
// ALU operand-A select with rs1 forwarding, registered into ID/EX; 1-cycle latency, holds exactly while ex_ready=0.
// Optional forwarding-hit counter (fwd_hits) is built when ALU_OPA_FWD_STATS_EN is defined.
module alu_opa_fwd_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int RADDR_W = 5
) (
`ifdef ALU_OPA_FWD_STATS_EN
  output logic [31:0]                fwd_hits,
`endif
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  output logic                       id_ready,
  input  logic [1:0]                 src_sel,
  input  logic [RADDR_W-1:0]         rs1_addr,
  input  logic [XLEN-1:0]            rs1_data,
  input  logic [XLEN-1:0]            pc_current,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  input  logic                       flush,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [XLEN-1:0]            alu_a,
  output logic                       alu_a_fwd
);

  logic            ex_valid_q;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic            alu_a_fwd_q, alu_a_fwd_d;
  logic            fwd_hit;
  logic [XLEN-1:0] rs1_res;
  logic            load;

  assign id_ready = !ex_valid_q || ex_ready;
  assign load     = id_valid && id_ready && !flush;

  // Walk from the oldest source down so the youngest hit overwrites and wins.
  always_comb begin
    fwd_hit = 1'b0;
    rs1_res = rs1_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_rd[i*RADDR_W +: RADDR_W] == rs1_addr) && (rs1_addr != '0)) begin
        fwd_hit = 1'b1;
        rs1_res = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    alu_a_d     = '0;
    alu_a_fwd_d = 1'b0;
    case (src_sel)
      2'd0: begin
        alu_a_d     = rs1_res;
        alu_a_fwd_d = fwd_hit;
      end
      2'd1:    alu_a_d = pc_current;
      default: alu_a_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_a_fwd_q <= 1'b0;
    end else if (flush) begin
      ex_valid_q  <= 1'b0;
    end else if (load) begin
      ex_valid_q  <= 1'b1;
      alu_a_q     <= alu_a_d;
      alu_a_fwd_q <= alu_a_fwd_d;
    end else if (ex_ready) begin
      ex_valid_q  <= 1'b0;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_a_fwd = alu_a_fwd_q;

`ifdef ALU_OPA_FWD_STATS_EN
  logic [31:0] fwd_hits_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hits_q <= '0;
    end else if (load && alu_a_fwd_d && (fwd_hits_q != 32'hFFFF_FFFF)) begin
      fwd_hits_q <= fwd_hits_q + 32'd1;
    end
  end

  assign fwd_hits = fwd_hits_q;
`endif

endmodule

// File: tb/tb_alu_opa_fwd_stage.sv
// Directed bench for alu_opa_fwd_stage: expected operands queued at load, checked when the entry appears.
module tb_alu_opa_fwd_stage;

  typedef struct packed {
    logic [31:0] a;
    logic        f;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [1:0]  src_sel;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data;
  logic [31:0] pc_current;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_a;
  logic        alu_a_fwd;
`ifdef ALU_OPA_FWD_STATS_EN
  logic [31:0] fwd_hits;
  logic [31:0] m_hits;
`endif

  int   npass;
  int   nfail;
  int   ntotal;
  exp_t sb[$];
  logic m_valid;
  exp_t held;

  alu_opa_fwd_stage dut (
`ifdef ALU_OPA_FWD_STATS_EN
    .fwd_hits   (fwd_hits),
`endif
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .src_sel    (src_sel),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data),
    .pc_current (pc_current),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .alu_a      (alu_a),
    .alu_a_fwd  (alu_a_fwd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one cycle of stimulus, then checks the result at the next negedge.
  task automatic step(input string tag, input logic v, input logic [1:0] sel,
                      input logic [4:0] ra, input logic [31:0] rd, input logic [31:0] pc,
                      input logic [1:0] fv, input logic [4:0] rd0, input logic [4:0] rd1,
                      input logic [31:0] fd0, input logic [31:0] fd1,
                      input logic fl, input logic er, input logic [31:0] exp_a, input logic exp_f);
    logic ld;
    exp_t e;
    id_valid   = v;
    src_sel    = sel;
    rs1_addr   = ra;
    rs1_data   = rd;
    pc_current = pc;
    fwd_valid  = fv;
    fwd_rd     = {rd1, rd0};
    fwd_data   = {fd1, fd0};
    flush      = fl;
    ex_ready   = er;
    #1;
    chk({tag, ".id_ready"}, {31'd0, id_ready}, {31'd0, (!m_valid || er)});
    ld = v && (!m_valid || er) && !fl;
    if (ld) sb.push_back('{a: exp_a, f: exp_f});
    @(posedge clk);
    if (fl) m_valid = 1'b0;
    else if (ld) m_valid = 1'b1;
    else if (er) m_valid = 1'b0;
`ifdef ALU_OPA_FWD_STATS_EN
    if (ld && exp_f) m_hits++;
`endif
    @(negedge clk);
    chk({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, m_valid});
    if (ld) begin
      chk({tag, ".sb_nonempty"}, {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e    = sb.pop_front();
        held = e;
      end
    end
    chk({tag, ".alu_a"}, alu_a, held.a);
    chk({tag, ".alu_a_fwd"}, {31'd0, alu_a_fwd}, {31'd0, held.f});
`ifdef ALU_OPA_FWD_STATS_EN
    chk({tag, ".fwd_hits"}, fwd_hits, m_hits);
`endif
  endtask

  initial begin
    npass = 0; nfail = 0; ntotal = 0;
    m_valid = 1'b0;
    held = '{a: 32'd0, f: 1'b0};
`ifdef ALU_OPA_FWD_STATS_EN
    m_hits = 32'd0;
`endif
    rst = 1'b1;
    id_valid = 1'b0; src_sel = 2'd0; rs1_addr = 5'd0; rs1_data = 32'd0; pc_current = 32'd0;
    fwd_valid = 2'b00; fwd_rd = '0; fwd_data = '0; flush = 1'b0; ex_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.alu_a", alu_a, 32'd0);
    chk("rst.alu_a_fwd", {31'd0, alu_a_fwd}, 32'd0);
    chk("rst.id_ready", {31'd0, id_ready}, 32'd1);
    rst = 1'b0;

    // Basic load, then consume with no new request
    step("t1_load", 1, 0, 5'd5, 32'h1111, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h1111, 0);
    step("t1_drain", 0, 0, 5'd5, 32'h2222, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h0, 0);

    // Forwarding priority
    step("t2_both", 1, 0, 5'd7, 32'h5555, 32'h0, 2'b11, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB, 0, 1, 32'hAAAA, 1);
    step("t2_src1", 1, 0, 5'd7, 32'h5555, 32'h0, 2'b10, 5'd7, 5'd7, 32'hAAAA, 32'hBBBB, 0, 1, 32'hBBBB, 1);
    step("t2_miss", 1, 0, 5'd7, 32'h5555, 32'h0, 2'b11, 5'd3, 5'd9, 32'hAAAA, 32'hBBBB, 0, 1, 32'h5555, 0);

    // x0 guard, PC and zero select (a live forward hit is present but must not matter)
    step("t3_x0", 1, 0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd0, 5'd0, 32'hDEAD, 32'h0, 0, 1, 32'h0, 0);
    step("t3_pc", 1, 1, 5'd7, 32'h5555, 32'h0000_0400, 2'b01, 5'd7, 5'd0, 32'hAAAA, 32'h0, 0, 1, 32'h400, 0);
    step("t3_pcfull", 1, 1, 5'd7, 32'h5555, 32'hFFFF_FFFC, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 1, 32'hFFFF_FFFC, 0);
    step("t3_sel3", 1, 3, 5'd7, 32'h5555, 32'h400, 2'b01, 5'd7, 5'd0, 32'hAAAA, 32'h0, 0, 1, 32'h0, 0);
    step("t3_sel2", 1, 2, 5'd7, 32'h5555, 32'h400, 2'b01, 5'd7, 5'd0, 32'hAAAA, 32'h0, 0, 1, 32'h0, 0);

    // Stall: held entry ignores changing inputs and late forwards, then back-to-back loads
    step("t4_load", 1, 0, 5'd4, 32'h1234, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h1234, 0);
    step("t4_st0", 1, 0, 5'd4, 32'h9999, 32'h0, 2'b01, 5'd4, 5'd0, 32'hCCCC, 32'h0, 0, 0, 32'h0, 0);
    step("t4_st1", 1, 1, 5'd4, 32'h8888, 32'h44, 2'b10, 5'd0, 5'd4, 32'h0, 32'hDDDD, 0, 0, 32'h0, 0);
    step("t4_st2", 1, 0, 5'd4, 32'h7777, 32'h0, 2'b11, 5'd4, 5'd4, 32'hEEEE, 32'hFFFF, 0, 0, 32'h0, 0);
    step("t4_b2b0", 1, 0, 5'd6, 32'h5678, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h5678, 0);
    step("t4_b2b1", 1, 0, 5'd6, 32'h0, 32'h0, 2'b10, 5'd0, 5'd6, 32'h0, 32'h9ABC, 0, 1, 32'h9ABC, 1);

    // Flush with a same-cycle handshake carrying a forward hit: discarded, not counted
    step("t5_flush", 1, 0, 5'd7, 32'h3333, 32'h0, 2'b01, 5'd7, 5'd0, 32'h4444, 32'h0, 1, 1, 32'h0, 0);
    step("t5_load", 1, 0, 5'd8, 32'h0ABC, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h0ABC, 0);
    step("t5_flstall", 1, 0, 5'd8, 32'h1, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1, 0, 32'h0, 0);

    // Async reset while stalled, asserted between edges
    step("t6_load", 1, 0, 5'd9, 32'h0, 32'h0, 2'b01, 5'd9, 5'd0, 32'h1234, 32'h0, 0, 1, 32'h1234, 1);
    step("t6_stall", 1, 0, 5'd9, 32'h6666, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6.ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("t6.alu_a", alu_a, 32'd0);
    chk("t6.alu_a_fwd", {31'd0, alu_a_fwd}, 32'd0);
`ifdef ALU_OPA_FWD_STATS_EN
    chk("t6.fwd_hits", fwd_hits, 32'd0);
    m_hits = 32'd0;
`endif
    m_valid = 1'b0;
    held = '{a: 32'd0, f: 1'b0};
    @(negedge clk);
    rst = 1'b0;
    step("t6_recover", 1, 0, 5'd2, 32'hCAFE, 32'h0, 2'b01, 5'd2, 5'd0, 32'hBEEF, 32'h0, 0, 1, 32'hBEEF, 1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
